alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, SHALL set the clocks each operation is held before its result is sampled (legal 2..15).
REQ-002 Parameter OP_FIRST, default 1, SHALL set the first select code driven.
REQ-003 Parameter OP_LAST, default 15, SHALL set the last select code driven (OP_FIRST <= OP_LAST <= 31).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 res  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  run request, sampled in IDLE only.
REQ-007 stop  in  1  synchronous abort, any state.
REQ-008 A_in, B_in  in  4 each  operand seeds, latched at start.
REQ-009 out  in  8  registered ALU result (1-clock latency after A/B/select change).
REQ-010 A, B  out  4 each  operands to ALU.
REQ-011 select  out  5  operation code to ALU.
REQ-012 busy  out  1  high while in RUN.
REQ-013 done  out  1  one-clock completion pulse.
REQ-014 last_out  out  8  most recently sampled result.
REQ-015 op_cnt  out  5  number of results sampled this run.
REQ-016 sig  out  16  result signature.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-018 IDLE with start=1, stop=0 at an edge: A<=A_in, B<=B_in, select<=OP_FIRST, hold counter<=0, op_cnt<=0, sig<=16'hFFFF, state<=RUN.
REQ-019 start SHALL be ignored in RUN and DONE; no restart, no relatch.
REQ-020 RUN: hold counter SHALL increment each edge; on the edge where it equals HOLD_CYCLES-1, out SHALL be sampled into last_out, op_cnt SHALL increment, sig SHALL update.
REQ-021 On that sampling edge: if select==OP_LAST state<=DONE and select holds; else select<=select+1, counter<=0.
REQ-022 A and B SHALL stay constant for the whole run.
REQ-023 With defaults a run SHALL be exactly 30 RUN clocks, 15 samples, then done high for one clock.
REQ-024 DONE SHALL assert done for exactly one clock, then go IDLE; A/B/select/last_out/op_cnt/sig SHALL hold until the next start.
REQ-025 stop=1 at any edge SHALL force IDLE with busy=0, done=0, and no sample taken that edge; stop wins over start and over a coincident sampling edge.
REQ-026 busy SHALL be a registered decode of RUN; done a registered decode of DONE.

Reset
REQ-027 res=0 SHALL immediately force IDLE, A=0, B=0, select=0, busy=0, done=0, last_out=0, op_cnt=0, sig=0, counter=0, regardless of clk.
REQ-028 Reset mid-run SHALL discard the run; no done pulse after release.
REQ-029 First start SHALL be accepted on the first edge after res rises.

Configuration
REQ-030 Macro ALU_SEQ_MISR_EN defined: each sample SHALL set sig <= {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} ^ {8'h00, out}.
REQ-031 Macro ALU_SEQ_MISR_EN undefined: each sample SHALL set sig <= sig + {8'h00, out} (mod 2^16); all other behaviour identical.

Verification
REQ-032 Defaults, res pulse, start with A_in=4'b0100, B_in=4'b1001 -> A/B constant, select 1..15 each held 2 clocks, busy 30 clocks, done one pulse, op_cnt=15.
REQ-033 Loopback stub out={3'b000,select} delayed one clock, both macro settings -> last_out=8'h0F; sig equals bench model (MISR seed FFFF / sum FFFF+120 = 16'h0077).
REQ-034 start held high through a run -> exactly one run per IDLE entry; next run begins edge after done.
REQ-035 stop asserted on a sampling edge of select=7 -> IDLE next edge, op_cnt=6, no done.
REQ-036 res low for 3 clocks during select=12 -> all outputs zero immediately, no done; new start after release runs normally.
REQ-037 HOLD_CYCLES=4, OP_FIRST=12, OP_LAST=13 -> busy 8 clocks, two samples, op_cnt=2, select ends at 13.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer that walks an external registered ALU through select codes OP_FIRST..OP_LAST,
// sampling each result into last_out/op_cnt/sig. Define ALU_SEQ_MISR_EN for a MISR signature (default: additive).
module alu_seq #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned OP_FIRST    = 1,
  parameter int unsigned OP_LAST     = 15,
  localparam int unsigned OPND_W     = 4,
  localparam int unsigned SEL_W      = 5,
  localparam int unsigned RES_W      = 8,
  localparam int unsigned SIG_W      = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              stop,
  input  logic [OPND_W-1:0] A_in,
  input  logic [OPND_W-1:0] B_in,
  input  logic [RES_W-1:0]  out,
  output logic [OPND_W-1:0] A,
  output logic [OPND_W-1:0] B,
  output logic [SEL_W-1:0]  select,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  last_out,
  output logic [SEL_W-1:0]  op_cnt,
  output logic [SIG_W-1:0]  sig
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [OPND_W-1:0] w_a_nxt;
  logic [OPND_W-1:0] w_b_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [RES_W-1:0]  w_last_nxt;
  logic [SEL_W-1:0]  w_opcnt_nxt;
  logic [SIG_W-1:0]  w_sig_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_hold_end;
  logic              w_sel_last;

  // Signature update applied once per sampled result
  function automatic logic [SIG_W-1:0] f_sig_step(input logic [SIG_W-1:0] s,
                                                  input logic [RES_W-1:0] d);
`ifdef ALU_SEQ_MISR_EN
    f_sig_step = {s[SIG_W-2:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, d};
`else
    f_sig_step = s + {8'h00, d};
`endif
  endfunction

  assign w_hold_end = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign w_sel_last = (select == SEL_W'(OP_LAST));

  // Next-state and next-output decode; stop overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = A;
    w_b_nxt     = B;
    w_sel_nxt   = select;
    w_last_nxt  = last_out;
    w_opcnt_nxt = op_cnt;
    w_sig_nxt   = sig;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_a_nxt     = A_in;
            w_b_nxt     = B_in;
            w_sel_nxt   = SEL_W'(OP_FIRST);
            w_cnt_nxt   = '0;
            w_opcnt_nxt = '0;
            w_sig_nxt   = 16'hFFFF;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (w_hold_end) begin
            w_last_nxt  = out;
            w_opcnt_nxt = op_cnt + SEL_W'(1);
            w_sig_nxt   = f_sig_step(sig, out);
            w_cnt_nxt   = '0;
            if (w_sel_last) begin
              w_state_nxt = S_DONE;
            end else begin
              w_sel_nxt = select + SEL_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      A        <= '0;
      B        <= '0;
      select   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      last_out <= '0;
      op_cnt   <= '0;
      sig      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      A        <= w_a_nxt;
      B        <= w_b_nxt;
      select   <= w_sel_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      last_out <= w_last_nxt;
      op_cnt   <= w_opcnt_nxt;
      sig      <= w_sig_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: default instance plus a HOLD_CYCLES=4, OP 12..13 instance,
// each driving a registered stub ALU; expected run results are queued at start and checked on done.
module tb_alu_seq;

  localparam int C0_HOLD = 2;
  localparam int C0_FIRST = 1;
  localparam int C0_LAST = 15;
  localparam int C1_HOLD = 4;
  localparam int C1_FIRST = 12;
  localparam int C1_LAST = 13;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [4:0]  sel;
    logic [4:0]  op_cnt;
    logic [7:0]  last_out;
    logic [15:0] sig;
    int          busy_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic res;
  logic start0, stop0, start1, stop1;
  logic [3:0] a_in0, b_in0, a_in1, b_in1;
  logic [7:0] alu_out0, alu_out1;
  logic [3:0] a0, b0, a1, b1;
  logic [4:0] sel0, sel1, opcnt0, opcnt1;
  logic busy0, done0, busy1, done1;
  logic [7:0] last0, last1;
  logic [15:0] sig0, sig1;

  int mode0, mode1;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int busy_cnt[2];
  bit sel_bad[2];
  bit ab_bad[2];

  always #5 clk = ~clk;

  alu_seq u_dut0 (
    .clk(clk), .res(res), .start(start0), .stop(stop0), .A_in(a_in0), .B_in(b_in0),
    .out(alu_out0), .A(a0), .B(b0), .select(sel0), .busy(busy0), .done(done0),
    .last_out(last0), .op_cnt(opcnt0), .sig(sig0)
  );

  alu_seq #(.HOLD_CYCLES(C1_HOLD), .OP_FIRST(C1_FIRST), .OP_LAST(C1_LAST)) u_dut1 (
    .clk(clk), .res(res), .start(start1), .stop(stop1), .A_in(a_in1), .B_in(b_in1),
    .out(alu_out1), .A(a1), .B(b1), .select(sel1), .busy(busy1), .done(done1),
    .last_out(last1), .op_cnt(opcnt1), .sig(sig1)
  );

  function automatic logic [7:0] alu_f(input int mode, input logic [3:0] a, input logic [3:0] b,
                                       input logic [4:0] sel);
    logic [7:0] r;
    case (mode)
      0:       r = {3'b000, sel};
      1:       r = ({a, b} ^ {sel, 3'b101}) + 8'(sel * sel);
      2:       r = 8'(a * b) + {3'b000, sel};
      default: r = {b, a} - {sel, 3'b011};
    endcase
    return r;
  endfunction

  // Registered stub ALUs: one clock from A/B/select to out
  always @(posedge clk or negedge res) begin
    if (!res) begin
      alu_out0 <= 8'h00;
      alu_out1 <= 8'h00;
    end else begin
      alu_out0 <= alu_f(mode0, a0, b0, sel0);
      alu_out1 <= alu_f(mode1, a1, b1, sel1);
    end
  end

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [7:0] d);
`ifdef ALU_SEQ_MISR_EN
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, d};
`else
    return s + {8'h00, d};
`endif
  endfunction

  function automatic int p_hold(input int ch);
    return (ch == 0) ? C0_HOLD : C1_HOLD;
  endfunction
  function automatic int p_first(input int ch);
    return (ch == 0) ? C0_FIRST : C1_FIRST;
  endfunction
  function automatic int p_last(input int ch);
    return (ch == 0) ? C0_LAST : C1_LAST;
  endfunction

  // Expected outputs after nsamp results of a run seeded with a/b
  function automatic exp_t model(input int ch, input logic [3:0] a, input logic [3:0] b,
                                 input int mode, input int nsamp);
    exp_t e;
    logic [15:0] s = 16'hFFFF;
    logic [7:0] lo = 8'h00;
    for (int k = 0; k < nsamp; k++) begin
      lo = alu_f(mode, a, b, 5'(p_first(ch) + k));
      s = sig_step(s, lo);
    end
    e.a = a;
    e.b = b;
    e.sel = 5'(p_first(ch) + nsamp - 1);
    e.op_cnt = 5'(nsamp);
    e.last_out = lo;
    e.sig = s;
    e.busy_cycles = nsamp * p_hold(ch);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_cycle(input int ch, input logic [3:0] a, input logic [3:0] b,
                           input logic [4:0] sel, input logic bz, input logic dn,
                           input logic [7:0] lo, input logic [4:0] oc, input logic [15:0] sg);
    exp_t e;
    bit have;
    string p;
    p = $sformatf("ch%0d_", ch);
    have = (ch == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (dn) begin
      chk({p, "done_has_run"}, 32'(have), 32'd1);
      if (have) begin
        if (ch == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({p, "last_out"}, 32'(lo), 32'(e.last_out));
        chk({p, "op_cnt"}, 32'(oc), 32'(e.op_cnt));
        chk({p, "sig"}, 32'(sg), 32'(e.sig));
        chk({p, "select_end"}, 32'(sel), 32'(e.sel));
        chk({p, "ab_end"}, 32'({a, b}), 32'({e.a, e.b}));
        chk({p, "busy_cycles"}, 32'(busy_cnt[ch]), 32'(e.busy_cycles));
        chk({p, "sel_schedule_bad"}, 32'(sel_bad[ch]), 32'd0);
        chk({p, "ab_changed"}, 32'(ab_bad[ch]), 32'd0);
        chk({p, "busy_at_done"}, 32'(bz), 32'd0);
      end
      busy_cnt[ch] = 0; sel_bad[ch] = 1'b0; ab_bad[ch] = 1'b0;
    end else if (bz) begin
      if (have) begin
        if (ch == 0) e = q0[0]; else e = q1[0];
        if ({a, b} !== {e.a, e.b}) ab_bad[ch] = 1'b1;
        if (busy_cnt[ch] >= e.busy_cycles ||
            sel !== 5'(p_first(ch) + busy_cnt[ch] / p_hold(ch))) sel_bad[ch] = 1'b1;
      end
      busy_cnt[ch]++;
    end else begin
      busy_cnt[ch] = 0; sel_bad[ch] = 1'b0; ab_bad[ch] = 1'b0;
    end
  endtask

  // Monitor: outputs sampled on the falling edge
  always @(negedge clk) begin
    mon_cycle(0, a0, b0, sel0, busy0, done0, last0, opcnt0, sig0);
    mon_cycle(1, a1, b1, sel1, busy1, done1, last1, opcnt1, sig1);
  end

  task automatic wait_done(input int ch, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = (ch == 0) ? done0 : done1;
    end
    chk($sformatf("ch%0d_done_seen", ch), 32'(seen), 32'd1);
  endtask

  // All run tasks are entered and left right after a falling edge
  task automatic run_normal(input int ch, input logic [3:0] a, input logic [3:0] b, input int mode);
    int n;
    n = p_last(ch) - p_first(ch) + 1;
    if (ch == 0) begin
      mode0 = mode; q0.push_back(model(0, a, b, mode, n));
      a_in0 = a; b_in0 = b; start0 = 1'b1;
    end else begin
      mode1 = mode; q1.push_back(model(1, a, b, mode, n));
      a_in1 = a; b_in1 = b; start1 = 1'b1;
    end
    @(negedge clk);
    if (ch == 0) begin
      start0 = 1'b0; chk("ch0_accept", 32'(busy0), 32'd1);
      a_in0 = 4'($urandom); b_in0 = 4'($urandom);
    end else begin
      start1 = 1'b0; chk("ch1_accept", 32'(busy1), 32'd1);
      a_in1 = 4'($urandom); b_in1 = 4'($urandom);
    end
    wait_done(ch, n * p_hold(ch) + 4);
    @(negedge clk);
    if (ch == 0) chk("ch0_idle_after_done", 32'({busy0, done0}), 32'd0);
    else chk("ch1_idle_after_done", 32'({busy1, done1}), 32'd0);
  endtask

  task automatic run_held(input logic [3:0] a, input logic [3:0] b, input logic [3:0] a2,
                          input logic [3:0] b2, input int mode);
    mode0 = mode;
    q0.push_back(model(0, a, b, mode, 15));
    a_in0 = a; b_in0 = b; start0 = 1'b1;
    @(negedge clk);
    chk("held_accept1", 32'(busy0), 32'd1);
    q0.push_back(model(0, a2, b2, mode, 15));
    a_in0 = a2; b_in0 = b2;
    wait_done(0, 40);
    @(negedge clk);
    chk("held_gap", 32'({busy0, done0}), 32'd0);
    @(negedge clk);
    chk("held_accept2", 32'(busy0), 32'd1);
    start0 = 1'b0;
    wait_done(0, 40);
    @(negedge clk);
    chk("held_idle_after", 32'({busy0, done0}), 32'd0);
  endtask

  // Abort with stop on the sampling edge of select code s
  task automatic run_abort(input logic [3:0] a, input logic [3:0] b, input int mode, input int s);
    exp_t e;
    int nsamp;
    nsamp = s - C0_FIRST;
    e = model(0, a, b, mode, nsamp);
    mode0 = mode;
    a_in0 = a; b_in0 = b; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("abort_accept", 32'(busy0), 32'd1);
    for (int j = 0; j < nsamp * C0_HOLD + C0_HOLD - 1; j++) @(negedge clk);
    chk("abort_sel_before", 32'(sel0), 32'(s));
    stop0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    start0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_op_cnt", 32'(opcnt0), 32'(e.op_cnt));
    chk("abort_select", 32'(sel0), 32'(s));
    chk("abort_last_out", 32'(last0), 32'(e.last_out));
    chk("abort_sig", 32'(sig0), 32'(e.sig));
    @(negedge clk);
    chk("abort_no_done", 32'({busy0, done0}), 32'd0);
  endtask

  task automatic run_reset_mid(input logic [3:0] a, input logic [3:0] b);
    mode0 = 0;
    a_in0 = a; b_in0 = b; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int j = 0; j < 22; j++) @(negedge clk);
    chk("rst_sel_before", 32'(sel0), 32'd12);
    #2 res = 1'b0;
    #1;
    chk("rst_ab", 32'({a0, b0}), 32'd0);
    chk("rst_select", 32'(sel0), 32'd0);
    chk("rst_flags", 32'({busy0, done0}), 32'd0);
    chk("rst_last_opcnt", 32'({last0, opcnt0}), 32'd0);
    chk("rst_sig", 32'(sig0), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done0), 32'd0);
    end
    res = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kind, s;
    res = 1'b0;
    start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    a_in0 = 4'h0; b_in0 = 4'h0; a_in1 = 4'h0; b_in1 = 4'h0;
    mode0 = 0; mode1 = 0;
    #12;
    chk("reset_ab", 32'({a0, b0, a1, b1}), 32'd0);
    chk("reset_sel", 32'({sel0, sel1}), 32'd0);
    chk("reset_flags", 32'({busy0, done0, busy1, done1}), 32'd0);
    chk("reset_results", 32'({last0, opcnt0}), 32'd0);
    chk("reset_sig", 32'({sig0, sig1}), 32'd0);
    @(negedge clk);
    res = 1'b1;
    run_normal(0, 4'b0100, 4'b1001, 0);
    chk("loopback_last_out", 32'(last0), 32'h0F);
    run_abort(4'h3, 4'hA, 1, 7);
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        run_normal(0, 4'($urandom), 4'($urandom), $urandom_range(0, 3));
      end else if (kind <= 7) begin
        s = $urandom_range(C0_FIRST + 1, C0_LAST);
        run_abort(4'($urandom), 4'($urandom), $urandom_range(0, 3), s);
      end else begin
        run_held(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
      end
    end
    run_reset_mid(4'h5, 4'hC);
    run_normal(0, 4'hE, 4'h1, 2);
    run_normal(1, 4'b0100, 4'b1001, 0);
    chk("ch1_select_end", 32'(sel1), 32'd13);
    for (int it = 0; it < 4; it++) begin
      run_normal(1, 4'($urandom), 4'($urandom), $urandom_range(0, 3));
    end
    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
